core_ctrl: RTL and testbench
============================

CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 Parameters SHALL be: row, default 8, PE rows; col, default 8, PE columns; num_act_max, default 64, maximum activation words per run; addr_w, default 11, SRAM address width.
REQ-002 Port clk, input, 1 bit, the single clock; every state element SHALL be updated on its rising edge.
REQ-003 Port reset, input, 1 bit, SHALL be a synchronous, active-low reset (low means reset).
REQ-004 Port start, input, 1 bit, SHALL request one run; it is sampled only in IDLE.
REQ-005 Port num_act, input, 7 bits, SHALL give the activation word count (0..num_act_max) and is latched at start.
REQ-006 Ports kbase, abase and pbase, input, addr_w bits each, SHALL give the kernel xmem base, the activation xmem base and the psum pmem base; all are latched at start.
REQ-007 Port ofifo_valid, input, 1 bit, SHALL indicate that the output FIFO holds a full row.
REQ-008 Port inst, output, 34 bits, SHALL be the registered instruction word driven to the core.
REQ-009 Port busy, output, 1 bit, SHALL be high in every state except IDLE.
REQ-010 Port done, output, 1 bit, SHALL pulse for one cycle at the end of each run.

Function
REQ-011 inst fields: [33] acc; [32] CEN_pmem; [31] WEN_pmem; [30:20] A_pmem; [19] CEN_xmem; [18] WEN_xmem; [17:7] A_xmem; [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load.
REQ-012 The idle inst value SHALL be 34'h1_800C_0000: both CEN and WEN high, all other bits 0. It is driven in IDLE and DONE.
REQ-013 States: IDLE, KL0, KARR, AL0, EXEC, DRAIN, DONE. Transitions: IDLE->KL0 on start; KL0->KARR; KARR->AL0; AL0->EXEC; EXEC->DRAIN; DRAIN->DONE; DONE->IDLE.
REQ-014 KL0 SHALL last col+1 cycles.
  - Cycles 0..col-1: xmem read (CEN=0, WEN=1), A_xmem = kbase+i.
  - Cycles 1..col: l0_wr=1. This covers the 1-cycle SRAM read latency.
REQ-015 KARR SHALL last col+row cycles with load=1; l0_rd=1 for the first col cycles only.
REQ-016 AL0 SHALL behave as KL0, using abase and num_act words, and SHALL last num_act+1 cycles.
REQ-017 EXEC SHALL last num_act+row+col cycles with execute=1; l0_rd=1 for the first num_act cycles only.
REQ-018 DRAIN write rule:
  - Each cycle with ofifo_valid=1: ofifo_rd=1, CEN_pmem=0, WEN_pmem=0, A_pmem = pbase+k, then k increments.
  - ofifo_valid=0: idle inst.
  - DRAIN ends after num_act writes.
REQ-019 Address arithmetic SHALL wrap modulo 2**addr_w. Example: pbase=2046 with 4 writes gives addresses 2046, 2047, 0, 1.
REQ-020 num_act=0 SHALL skip AL0, EXEC and DRAIN (KARR->DONE).
REQ-021 num_act>num_act_max SHALL be clamped to num_act_max at latch time.
REQ-022 start asserted while busy SHALL be ignored; it is not queued.
REQ-023 inst SHALL come directly from a register, with no combinational path from inputs to inst.

Reset
REQ-024 While reset=0 at a clock edge, on that edge:
  - state <= IDLE;
  - inst <= 34'h1_800C_0000;
  - busy <= 0 and done <= 0;
  - all counters and latched bases <= 0.
REQ-025 Reset SHALL take effect mid-run in any state; the next run starts cleanly from IDLE.

Configuration
REQ-026 Macro CORE_CTRL_ACC_EN defined:
  - an input port acc_mode (1 bit) SHALL exist and is latched at start;
  - inst[33] SHALL equal the latched acc_mode on every DRAIN write cycle, and 0 otherwise.
REQ-027 Macro CORE_CTRL_ACC_EN undefined: acc_mode SHALL be absent and inst[33] SHALL be constant 0.

Structure
REQ-028 A shared package SHALL hold the inst bit/field position constants, the idle inst value and the state enum typedef; core and testbench import it.
REQ-029 The block SHALL be a single module with no sub-modules. The state register and the phase counter SHALL be the only sequential structures besides the output registers.

Verification
REQ-030 The bench SHALL cover these scenarios:
  - Reset, then idle: inst=34'h1_800C_0000, busy=0, done=0.
  - start, kbase=0, abase=16, pbase=0, num_act=4, ofifo_valid=1 throughout:
    - KL0 addresses 0..7;
    - AL0 addresses 16..19;
    - 4 pmem writes at 0..3;
    - done pulses once, at run cycle 9+16+5+20+4 = 54.
  - num_act=4 with ofifo_valid toggling 1,0,1,0...: exactly 4 writes, with no address skipped.
  - pbase=2046, num_act=4: A_pmem sequence 2046, 2047, 0, 1.
  - num_act=0: run ends after KARR; no execute, no pmem write.
  - reset=0 during EXEC: the next cycle shows IDLE and the idle inst; a following start runs to completion.

Source files
------------

// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core controller: instruction word layout,
// the idle instruction value and the controller state encoding.
// Imported by the controller RTL and by its testbench.
package core_ctrl_pkg;

    // Instruction word geometry
    localparam int INST_W = 34;
    localparam int A_W    = 11;

    // Instruction bit and field positions
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_PMEM = 32;
    localparam int INST_WEN_PMEM = 31;
    localparam int A_PMEM_MSB    = 30;
    localparam int A_PMEM_LSB    = 20;
    localparam int INST_CEN_XMEM = 19;
    localparam int INST_WEN_XMEM = 18;
    localparam int A_XMEM_MSB    = 17;
    localparam int A_XMEM_LSB    = 7;
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_LOAD     = 0;

    // Both SRAMs deselected and write-disabled, every strobe low
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    // Controller phases in run order
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KL0   = 3'd1,
        ST_KARR  = 3'd2,
        ST_AL0   = 3'd3,
        ST_EXEC  = 3'd4,
        ST_DRAIN = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

endpackage

// File: rtl/core_ctrl.sv
// Sequences one systolic-core run: kernel load to L0, kernel load into the
// array, activation load to L0, execute, then drain output rows to psum SRAM.
// inst/busy/done are registered; optional accumulate mode via CORE_CTRL_ACC_EN.
module core_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int row         = 8,
    parameter int col         = 8,
    parameter int num_act_max = 64,
    parameter int addr_w      = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [6:0]        num_act,
    input  logic [addr_w-1:0] kbase,
    input  logic [addr_w-1:0] abase,
    input  logic [addr_w-1:0] pbase,
`ifdef CORE_CTRL_ACC_EN
    input  logic              acc_mode,
`endif
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              busy,
    output logic              done
);

    // Phase counter must reach num_act_max + row + col - 1 (longest EXEC)
    localparam int CNT_W = $clog2(num_act_max + row + col + 1) + 1;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] COL_N     = CNT_W'(col);
    localparam logic [CNT_W-1:0] KL0_LAST  = CNT_W'(col);
    localparam logic [CNT_W-1:0] KARR_LAST = CNT_W'(col + row - 1);
    localparam logic [CNT_W-1:0] ROW_COL   = CNT_W'(row + col);
    localparam logic [6:0]       ACT_MAX   = 7'(num_act_max);

    // Phase state and per-phase cycle counter (write count while draining)
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Run parameters captured at start
    logic [6:0]        num_act_q, num_act_d;
    logic [addr_w-1:0] kbase_q, kbase_d;
    logic [addr_w-1:0] abase_q, abase_d;
    logic [addr_w-1:0] pbase_q, pbase_d;
    logic              acc_q, acc_d;

    // Output registers
    logic [INST_W-1:0] inst_q, inst_d;
    logic              busy_q, done_q;

    // The upcoming cycle is a psum write
    logic              wr_d;

    // Activation count widened to counter width, current and next run
    logic [CNT_W-1:0]  act_q_n;
    logic [CNT_W-1:0]  act_d_n;

    assign act_q_n = CNT_W'(num_act_q);
    assign act_d_n = CNT_W'(num_act_d);

    // Next phase, counter and latched run parameters
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = 1'b0;
        num_act_d = num_act_q;
        kbase_d   = kbase_q;
        abase_d   = abase_q;
        pbase_d   = pbase_q;
        acc_d     = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_KL0;
                    cnt_d     = '0;
                    num_act_d = (int'(num_act) > num_act_max) ? ACT_MAX : num_act;
                    kbase_d   = kbase;
                    abase_d   = abase;
                    pbase_d   = pbase;
`ifdef CORE_CTRL_ACC_EN
                    acc_d     = acc_mode;
`else
                    acc_d     = 1'b0;
`endif
                end
            end
            ST_KL0: begin
                if (cnt_q == KL0_LAST) begin
                    state_d = ST_KARR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_KARR: begin
                if (cnt_q == KARR_LAST) begin
                    // An empty run has nothing to load, execute or drain
                    state_d = (num_act_q == '0) ? ST_DONE : ST_AL0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_AL0: begin
                if (cnt_q == act_q_n) begin
                    state_d = ST_EXEC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_EXEC: begin
                if (cnt_q == act_q_n + ROW_COL - ONE) begin
                    // A row already waiting is written on the first drain cycle
                    state_d = ST_DRAIN;
                    wr_d    = ofifo_valid;
                    cnt_d   = ofifo_valid ? ONE : '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DRAIN: begin
                // cnt_q counts writes issued so far, including the current cycle
                if (cnt_q == act_q_n) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                end else if (ofifo_valid) begin
                    wr_d  = 1'b1;
                    cnt_d = cnt_q + ONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Instruction word for the upcoming cycle, decoded from the next phase
    always_comb begin
        inst_d = INST_IDLE;
        unique case (state_d)
            ST_KL0: begin
                if (cnt_d < COL_N) begin
                    inst_d[INST_CEN_XMEM]         = 1'b0;
                    inst_d[A_XMEM_MSB:A_XMEM_LSB] = A_W'(kbase_d + addr_w'(cnt_d));
                end
                // SRAM data arrives one cycle after its address
                inst_d[INST_L0_WR] = (cnt_d != '0);
            end
            ST_KARR: begin
                inst_d[INST_LOAD]  = 1'b1;
                inst_d[INST_L0_RD] = (cnt_d < COL_N);
            end
            ST_AL0: begin
                if (cnt_d < act_d_n) begin
                    inst_d[INST_CEN_XMEM]         = 1'b0;
                    inst_d[A_XMEM_MSB:A_XMEM_LSB] = A_W'(abase_d + addr_w'(cnt_d));
                end
                inst_d[INST_L0_WR] = (cnt_d != '0);
            end
            ST_EXEC: begin
                inst_d[INST_EXECUTE] = 1'b1;
                inst_d[INST_L0_RD]   = (cnt_d < act_d_n);
            end
            ST_DRAIN: begin
                if (wr_d) begin
                    inst_d[INST_OFIFO_RD]         = 1'b1;
                    inst_d[INST_CEN_PMEM]         = 1'b0;
                    inst_d[INST_WEN_PMEM]         = 1'b0;
                    // Address wraps naturally at the addr_w boundary
                    inst_d[A_PMEM_MSB:A_PMEM_LSB] = A_W'(pbase_d + addr_w'(cnt_d - ONE));
                    inst_d[INST_ACC]              = acc_d;
                end
            end
            default: begin
                inst_d = INST_IDLE;
            end
        endcase
    end

    // State, counter, latched parameters and outputs; synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            num_act_q <= '0;
            kbase_q   <= '0;
            abase_q   <= '0;
            pbase_q   <= '0;
            acc_q     <= 1'b0;
            inst_q    <= INST_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            num_act_q <= num_act_d;
            kbase_q   <= kbase_d;
            abase_q   <= abase_d;
            pbase_q   <= pbase_d;
            acc_q     <= acc_d;
            inst_q    <= inst_d;
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign inst = inst_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_core_ctrl.sv
// Directed testbench for core_ctrl: reset, full run, toggling drain,
// address wrap, empty run, clamp, start while busy and mid-run reset.
module tb_core_ctrl;
    import core_ctrl_pkg::*;

    logic              clk;
    logic              reset;
    logic              start;
    logic [6:0]        num_act;
    logic [10:0]       kbase, abase, pbase;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              busy, done;
`ifdef CORE_CTRL_ACC_EN
    logic              acc_mode;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Per-run observations
    int rd_addr[$];
    int wr_addr[$];
    int n_load, n_exec, n_l0wr, n_l0rd, n_ofrd, n_acc, n_busy, n_done;
    int done_cyc;
    int timed_out;

    core_ctrl #(
        .row(8), .col(8), .num_act_max(64), .addr_w(11)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_act(num_act),
        .kbase(kbase),
        .abase(abase),
        .pbase(pbase),
`ifdef CORE_CTRL_ACC_EN
        .acc_mode(acc_mode),
`endif
        .ofifo_valid(ofifo_valid),
        .inst(inst),
        .busy(busy),
        .done(done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive run parameters and a start pulse; returns on run cycle 0
    task automatic launch(input int kb, input int ab, input int pb, input int na);
        kbase   = 11'(kb);
        abase   = 11'(ab);
        pbase   = 11'(pb);
        num_act = 7'(na);
        start   = 1'b1;
        @(negedge clk);
    endtask

    // Observe one run from cycle 0 until it returns to idle
    task automatic collect(input int max_cyc, input int ofv_mode, input int start_hold);
        int c;
        rd_addr.delete();
        wr_addr.delete();
        n_load = 0; n_exec = 0; n_l0wr = 0; n_l0rd = 0; n_ofrd = 0;
        n_acc = 0; n_busy = 0; n_done = 0; done_cyc = -1; timed_out = 0;
        c = 0;
        forever begin
            if (inst[INST_CEN_XMEM] == 1'b0)
                rd_addr.push_back(int'(inst[A_XMEM_MSB:A_XMEM_LSB]));
            if (inst[INST_CEN_PMEM] == 1'b0 && inst[INST_WEN_PMEM] == 1'b0)
                wr_addr.push_back(int'(inst[A_PMEM_MSB:A_PMEM_LSB]));
            if (inst[INST_LOAD])     n_load++;
            if (inst[INST_EXECUTE])  n_exec++;
            if (inst[INST_L0_WR])    n_l0wr++;
            if (inst[INST_L0_RD])    n_l0rd++;
            if (inst[INST_OFIFO_RD]) n_ofrd++;
            if (inst[INST_ACC])      n_acc++;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                done_cyc = c;
            end
            if (!busy && n_done > 0) break;
            if (c >= max_cyc) begin
                timed_out = 1;
                break;
            end
            ofifo_valid = (ofv_mode == 0) ? 1'b1 : ((c % 2) == 0);
            start = (c < start_hold);
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        ofifo_valid = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (inst !== 34'h1_800C_0000) begin
            n_fail++; $display("FAIL reset_inst: got %h expected %h", inst, 34'h1_800C_0000);
        end
        n_assert++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b done=%b expected 0 0", busy, done);
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_assert++;
        if (inst !== 34'h1_800C_0000 || busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: inst=%h busy=%b expected 1800c0000 0", inst, busy);
        end
    endtask

    // Full run with held start to show start is not queued while busy
    task automatic test_basic_run();
        int exp_rd[12];
        for (int i = 0; i < 8; i++) exp_rd[i] = i;
        for (int i = 0; i < 4; i++) exp_rd[8 + i] = 16 + i;
        launch(0, 16, 0, 4);
        collect(400, 0, 20);
        n_assert++;
        if (timed_out != 0) begin
            n_fail++; $display("FAIL basic_timeout: run did not finish, done seen %0d", n_done);
        end
        n_assert++;
        if (rd_addr.size() != 12) begin
            n_fail++; $display("FAIL basic_rd_count: got %0d expected 12", rd_addr.size());
        end
        for (int i = 0; i < 12; i++) begin
            n_assert++;
            if (i >= rd_addr.size() || rd_addr[i] != exp_rd[i]) begin
                n_fail++;
                $display("FAIL basic_rd_addr[%0d]: got %0d expected %0d", i,
                         (i < rd_addr.size()) ? rd_addr[i] : -1, exp_rd[i]);
            end
        end
        n_assert++;
        if (wr_addr.size() != 4) begin
            n_fail++; $display("FAIL basic_wr_count: got %0d expected 4", wr_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (i >= wr_addr.size() || wr_addr[i] != i) begin
                n_fail++;
                $display("FAIL basic_wr_addr[%0d]: got %0d expected %0d", i,
                         (i < wr_addr.size()) ? wr_addr[i] : -1, i);
            end
        end
        n_assert++;
        if (done_cyc != 54 || n_done != 1) begin
            n_fail++; $display("FAIL basic_done: cycle %0d count %0d expected cycle 54 count 1", done_cyc, n_done);
        end
        n_assert++;
        if (n_load != 16 || n_exec != 20) begin
            n_fail++; $display("FAIL basic_load_exec: load %0d exec %0d expected 16 20", n_load, n_exec);
        end
        n_assert++;
        if (n_l0wr != 12 || n_l0rd != 12) begin
            n_fail++; $display("FAIL basic_l0: wr %0d rd %0d expected 12 12", n_l0wr, n_l0rd);
        end
        n_assert++;
        if (n_busy != 55 || n_ofrd != 4) begin
            n_fail++; $display("FAIL basic_busy_ofrd: busy %0d ofifo_rd %0d expected 55 4", n_busy, n_ofrd);
        end
        n_assert++;
`ifdef CORE_CTRL_ACC_EN
        if (n_acc != 4) begin
            n_fail++; $display("FAIL basic_acc: got %0d expected 4", n_acc);
        end
`else
        if (n_acc != 0) begin
            n_fail++; $display("FAIL basic_acc: got %0d expected 0", n_acc);
        end
`endif
        // The start held during the run must not launch a second one
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_assert++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL start_not_queued: busy=%b expected 0 at idle cycle %0d", busy, i);
            end
        end
    endtask

    task automatic test_toggle_drain();
        launch(0, 16, 40, 4);
        collect(400, 1, 0);
        n_assert++;
        if (wr_addr.size() != 4) begin
            n_fail++; $display("FAIL toggle_wr_count: got %0d expected 4", wr_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (i >= wr_addr.size() || wr_addr[i] != 40 + i) begin
                n_fail++;
                $display("FAIL toggle_wr_addr[%0d]: got %0d expected %0d", i,
                         (i < wr_addr.size()) ? wr_addr[i] : -1, 40 + i);
            end
        end
        n_assert++;
        if (done_cyc != 58 || n_done != 1) begin
            n_fail++; $display("FAIL toggle_done: cycle %0d count %0d expected 58 1", done_cyc, n_done);
        end
    endtask

    task automatic test_wrap();
        int exp_wr[4];
        exp_wr[0] = 2046; exp_wr[1] = 2047; exp_wr[2] = 0; exp_wr[3] = 1;
        launch(2044, 2047, 2046, 4);
        collect(400, 0, 0);
        n_assert++;
        if (wr_addr.size() != 4) begin
            n_fail++; $display("FAIL wrap_wr_count: got %0d expected 4", wr_addr.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_assert++;
            if (i >= wr_addr.size() || wr_addr[i] != exp_wr[i]) begin
                n_fail++;
                $display("FAIL wrap_wr_addr[%0d]: got %0d expected %0d", i,
                         (i < wr_addr.size()) ? wr_addr[i] : -1, exp_wr[i]);
            end
        end
        // Kernel reads 2044..2047,0..3 and activation reads 2047,0,1,2
        n_assert++;
        if (rd_addr.size() != 12 || rd_addr[4] != 0 || rd_addr[9] != 0) begin
            n_fail++; $display("FAIL wrap_rd: count %0d rd[4] %0d rd[9] %0d expected 12 0 0",
                               rd_addr.size(), (rd_addr.size() > 4) ? rd_addr[4] : -1,
                               (rd_addr.size() > 9) ? rd_addr[9] : -1);
        end
    endtask

    task automatic test_zero_act();
        launch(5, 16, 0, 0);
        collect(400, 0, 0);
        n_assert++;
        if (n_exec != 0 || wr_addr.size() != 0) begin
            n_fail++; $display("FAIL zero_no_exec: exec %0d writes %0d expected 0 0", n_exec, wr_addr.size());
        end
        n_assert++;
        if (done_cyc != 25 || n_done != 1) begin
            n_fail++; $display("FAIL zero_done: cycle %0d count %0d expected 25 1", done_cyc, n_done);
        end
        n_assert++;
        if (rd_addr.size() != 8 || rd_addr[0] != 5 || rd_addr[7] != 12 || n_load != 16) begin
            n_fail++; $display("FAIL zero_kernel: reads %0d load %0d expected 8 16", rd_addr.size(), n_load);
        end
    endtask

    task automatic test_clamp();
        launch(0, 0, 0, 100);
        collect(1000, 0, 0);
        n_assert++;
        if (wr_addr.size() != 64 || n_exec != 80) begin
            n_fail++; $display("FAIL clamp_counts: writes %0d exec %0d expected 64 80", wr_addr.size(), n_exec);
        end
        n_assert++;
        if (done_cyc != 234) begin
            n_fail++; $display("FAIL clamp_done: cycle %0d expected 234", done_cyc);
        end
    endtask

    task automatic test_reset_mid_run();
        launch(0, 16, 0, 4);
        start = 1'b0;
        repeat (35) @(negedge clk);
        n_assert++;
        if (inst[INST_EXECUTE] !== 1'b1) begin
            n_fail++; $display("FAIL midrun_in_exec: execute=%b expected 1", inst[INST_EXECUTE]);
        end
        reset = 1'b0;
        @(negedge clk);
        n_assert++;
        if (inst !== 34'h1_800C_0000 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset: inst=%h busy=%b done=%b expected 1800c0000 0 0", inst, busy, done);
        end
        reset = 1'b1;
        @(negedge clk);
        launch(8, 32, 100, 2);
        collect(400, 0, 0);
        n_assert++;
        if (done_cyc != 48 || n_done != 1) begin
            n_fail++; $display("FAIL midrun_rerun_done: cycle %0d count %0d expected 48 1", done_cyc, n_done);
        end
        n_assert++;
        if (wr_addr.size() != 2 || wr_addr[0] != 100 || wr_addr[1] != 101) begin
            n_fail++; $display("FAIL midrun_rerun_wr: count %0d expected 2 at 100,101", wr_addr.size());
        end
        n_assert++;
        if (rd_addr.size() != 10 || rd_addr[0] != 8 || rd_addr[8] != 32 || rd_addr[9] != 33) begin
            n_fail++; $display("FAIL midrun_rerun_rd: count %0d expected 10", rd_addr.size());
        end
    endtask

    initial begin
        reset       = 1'b0;
        start       = 1'b0;
        num_act     = '0;
        kbase       = '0;
        abase       = '0;
        pbase       = '0;
        ofifo_valid = 1'b1;
`ifdef CORE_CTRL_ACC_EN
        acc_mode    = 1'b1;
`endif
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_toggle_drain();
        test_wrap();
        test_zero_act();
        test_clamp();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
